// File: rtl/hk_spi_passthru.sv
// Housekeeping SPI slave for the management area.
//
// Gives an external host register access (manufacturer/product/user IDs and a CPU
// reset control bit) over 4-wire SPI. It also offers a pass-thru mode: the host SPI
// is routed straight to the management flash pads while the CPU is held in reset.
//
// Ports:
//   clock, resetb                  system clock, async active-low reset
//   sck, csb, sdi, sdo, sdo_enb    host SPI (sck/csb/sdi asynchronous to clock)
//   cpu_reset                      holds the management CPU in reset when 1
//   soc_flash_csb/clk/io0/io1      SoC flash controller side
//   flash_csb/clk/io0/io1          management flash pads
//
// Optional build macro USER_PASSTHRU_EN adds user_flash_csb/clk/io0/io1 and the
// 0xC6 command, which routes the host SPI to those ports without resetting the CPU.
//
// Command byte: 0x00 no-op, 0x80/0x40/0xC0 write/read/read-write stream,
// bits 5:3 = n != 0 select a counted transfer of n bytes, 0xC4 pass-thru.
// Any other command is ignored until csb rises.

module hk_spi_passthru #(
  parameter logic [11:0] MFGR_ID = 12'h456,
  parameter logic [7:0]  PROD_ID = 8'h10,
  parameter logic [31:0] USER_ID = 32'h0
) (
  input  logic clock,
  input  logic resetb,
  input  logic sck,
  input  logic csb,
  input  logic sdi,
  output logic sdo,
  output logic sdo_enb,
  output logic cpu_reset,
  input  logic soc_flash_csb,
  input  logic soc_flash_clk,
  input  logic soc_flash_io0,
  output logic soc_flash_io1,
  output logic flash_csb,
  output logic flash_clk,
  output logic flash_io0,
  input  logic flash_io1
`ifdef USER_PASSTHRU_EN
  ,
  output logic user_flash_csb,
  output logic user_flash_clk,
  output logic user_flash_io0,
  input  logic user_flash_io1
`endif
);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StData, StPass} state_t;

  // Synchronizers and edge detection
  logic sck_s1, sck_s2, sck_d;
  logic csb_s1, csb_s2, csb_d;
  logic sdi_s1, sdi_s2;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_d  <= 1'b0;
      csb_s1 <= 1'b1;
      csb_s2 <= 1'b1;
      csb_d  <= 1'b1;
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
    end else begin
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      csb_s1 <= csb;
      csb_s2 <= csb_s1;
      csb_d  <= csb_s2;
      sdi_s1 <= sdi;
      sdi_s2 <= sdi_s1;
    end
  end

  logic sck_rise, sck_fall, csb_fall;
  assign sck_rise = sck_s2 & ~sck_d;
  assign sck_fall = ~sck_s2 & sck_d;
  assign csb_fall = ~csb_s2 & csb_d;

  // Protocol state
  state_t      state_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic [7:0]  addr_q;
  logic [2:0]  cnt_q;
  logic        counted_q;
  logic        wr_q;
  logic        rd_q;
  logic        load_q;     // next falling sck loads the read shifter
  logic [7:0]  out_sr_q;
  logic        cpu_rst_q;

  logic [7:0]  byte_in;
  logic        byte_done;
  logic        shifting;
  logic [7:0]  rd_data;

  assign byte_in   = {shift_q, sdi_s2};
  assign shifting  = (state_q == StCmd) || (state_q == StAddr) || (state_q == StData);
  assign byte_done = sck_rise && shifting && (bit_cnt_q == 3'd7);

  always_comb begin
    rd_data = 8'h00;
    case (addr_q)
      8'h01:   rd_data = {4'h0, MFGR_ID[11:8]};
      8'h02:   rd_data = MFGR_ID[7:0];
      8'h03:   rd_data = PROD_ID;
      8'h04:   rd_data = USER_ID[31:24];
      8'h05:   rd_data = USER_ID[23:16];
      8'h06:   rd_data = USER_ID[15:8];
      8'h07:   rd_data = USER_ID[7:0];
      8'h08:   rd_data = {7'h00, cpu_rst_q};
      default: rd_data = 8'h00;
    endcase
  end

  logic pass_user;
`ifdef USER_PASSTHRU_EN
  logic pass_user_q;
  assign pass_user = pass_user_q;
`else
  assign pass_user = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      counted_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      load_q    <= 1'b0;
      out_sr_q  <= '0;
      cpu_rst_q <= 1'b0;
`ifdef USER_PASSTHRU_EN
      pass_user_q <= 1'b0;
`endif
    end else if (csb_s2) begin
      // Deselected: abandon any frame in progress, keep register contents.
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      counted_q <= 1'b0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      load_q    <= 1'b0;
      out_sr_q  <= '0;
`ifdef USER_PASSTHRU_EN
      pass_user_q <= 1'b0;
`endif
    end else begin
      if (sck_rise && shifting) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= byte_in[6:0];
      end
      unique case (state_q)
        StIdle: begin
          if (csb_fall) begin
            state_q   <= StCmd;
            bit_cnt_q <= '0;
          end
        end
        StCmd: begin
          if (byte_done) begin
            if (byte_in == 8'hC4) begin
              state_q <= StPass;
`ifdef USER_PASSTHRU_EN
            end else if (byte_in == 8'hC6) begin
              state_q     <= StPass;
              pass_user_q <= 1'b1;
`endif
            end else if (byte_in[2:0] == 3'b000 && byte_in[7:6] != 2'b00) begin
              wr_q      <= byte_in[7];
              rd_q      <= byte_in[6];
              cnt_q     <= byte_in[5:3];
              counted_q <= |byte_in[5:3];
              state_q   <= StAddr;
            end else begin
              // No-op or unknown: sit idle until csb rises.
              state_q <= StIdle;
            end
          end
        end
        StAddr: begin
          if (byte_done) begin
            addr_q  <= byte_in;
            load_q  <= rd_q;
            state_q <= StData;
          end
        end
        StData: begin
          if (sck_fall) begin
            if (load_q) begin
              out_sr_q <= rd_data;
              load_q   <= 1'b0;
            end else begin
              out_sr_q <= {out_sr_q[6:0], 1'b0};
            end
          end
          if (byte_done) begin
            if (wr_q && addr_q == 8'h08) cpu_rst_q <= byte_in[0];
            addr_q <= addr_q + 8'd1;
            if (counted_q && cnt_q == 3'd1) begin
              state_q <= StIdle;
              rd_q    <= 1'b0;
            end else begin
              load_q <= rd_q;
              if (counted_q) cnt_q <= cnt_q - 3'd1;
            end
          end
        end
        StPass: begin
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pass-thru ends as soon as the synchronized csb is seen high, which releases
  // cpu_reset two clocks after the raw csb rise; flash_csb follows raw csb directly.
  logic pass_on, mgmt_pass, user_pass, user_io1;
  assign pass_on   = (state_q == StPass) && !csb_s2;
  assign mgmt_pass = pass_on && !pass_user;
  assign user_pass = pass_on && pass_user;

`ifdef USER_PASSTHRU_EN
  assign user_io1       = user_flash_io1;
  assign user_flash_csb = user_pass ? csb : 1'b1;
  assign user_flash_clk = user_pass ? sck : 1'b0;
  assign user_flash_io0 = user_pass ? sdi : 1'b0;
`else
  assign user_io1 = 1'b0;
`endif

  assign flash_csb     = mgmt_pass ? csb : soc_flash_csb;
  assign flash_clk     = mgmt_pass ? sck : soc_flash_clk;
  assign flash_io0     = mgmt_pass ? sdi : soc_flash_io0;
  assign soc_flash_io1 = flash_io1;
  assign cpu_reset     = cpu_rst_q | mgmt_pass;
  // Released immediately by raw csb; csb_s2 holds it off during reset.
  assign sdo_enb       = csb | csb_s2;

  always_comb begin
    sdo = 1'b0;
    if (mgmt_pass)                          sdo = flash_io1;
    else if (user_pass)                     sdo = user_io1;
    else if (state_q == StData && rd_q)     sdo = out_sr_q[7];
  end

endmodule

// File: tb/tb_hk_spi_passthru.sv
module tb_hk_spi_passthru;

  localparam int HALF = 5;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  logic sck = 1'b0;
  logic csb = 1'b1;
  logic sdi = 1'b0;
  logic sdo, sdo_enb, cpu_reset;
  logic soc_flash_csb = 1'b1;
  logic soc_flash_clk = 1'b0;
  logic soc_flash_io0 = 1'b0;
  logic soc_flash_io1, flash_csb, flash_clk, flash_io0, flash_io1;
`ifdef USER_PASSTHRU_EN
  logic user_flash_csb, user_flash_clk, user_flash_io0;
  logic user_flash_io1 = 1'b0;
`endif

  hk_spi_passthru dut (
    .clock         (clock),
    .resetb        (resetb),
    .sck           (sck),
    .csb           (csb),
    .sdi           (sdi),
    .sdo           (sdo),
    .sdo_enb       (sdo_enb),
    .cpu_reset     (cpu_reset),
    .soc_flash_csb (soc_flash_csb),
    .soc_flash_clk (soc_flash_clk),
    .soc_flash_io0 (soc_flash_io0),
    .soc_flash_io1 (soc_flash_io1),
    .flash_csb     (flash_csb),
    .flash_clk     (flash_clk),
    .flash_io0     (flash_io0),
    .flash_io1     (flash_io1)
`ifdef USER_PASSTHRU_EN
    ,
    .user_flash_csb(user_flash_csb),
    .user_flash_clk(user_flash_clk),
    .user_flash_io0(user_flash_io0),
    .user_flash_io1(user_flash_io1)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_regs [256];
  logic [7:0] rbuf [16];
  logic [7:0] wbuf [16];

  // Flash model: 32 bits of command/address in, then bytes out from flash_mem.
  logic [7:0]  flash_mem [8];
  int          fl_cnt = 0;
  int          fl_base = 0;
  logic [31:0] fl_rx = '0;
  logic [2:0]  fl_addr = '0;
  logic        fl_io1 = 1'b0;

  assign flash_io1 = flash_csb ? 1'b0 : fl_io1;

  always @(posedge flash_clk or posedge flash_csb) begin
    if (flash_csb) begin
      fl_cnt = 0;
    end else begin
      fl_rx  = {fl_rx[30:0], flash_io0};
      fl_cnt = fl_cnt + 1;
      if (fl_cnt - fl_base == 32) fl_addr = fl_rx[2:0];
    end
  end

  always @(negedge flash_clk) begin
    int k;
    k = fl_cnt - fl_base - 32;
    if (!flash_csb && k >= 0) fl_io1 = flash_mem[(int'(fl_addr) + k / 8) % 8][7 - k % 8];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      sdi = tx[i];
      tick(HALF);
      rx[i] = sdo;
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic cs_low();
    csb = 1'b0;
    tick(6);
  endtask

  task automatic cs_high();
    tick(2);
    csb = 1'b1;
    tick(6);
  endtask

  task automatic frame_read(input logic [7:0] cmd, input logic [7:0] addr, input int n);
    logic [7:0] rx;
    cs_low();
    xfer(cmd, rx);
    xfer(addr, rx);
    for (int i = 0; i < n; i++) begin
      xfer(8'h00, rx);
      rbuf[i] = rx;
    end
    cs_high();
  endtask

  task automatic frame_write(input logic [7:0] cmd, input logic [7:0] addr, input int n);
    logic [7:0] rx;
    cs_low();
    xfer(cmd, rx);
    xfer(addr, rx);
    for (int i = 0; i < n; i++) begin
      xfer(wbuf[i], rx);
      rbuf[i] = rx;
    end
    cs_high();
  endtask

  // Only bit0 of register 0x08 is writable.
  task automatic ref_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h08) ref_regs[8] = {7'h00, d[0]};
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] a, idx;
    int         n, op;

    for (int i = 0; i < 256; i++) ref_regs[i] = 8'h00;
    ref_regs[1] = 8'h04;
    ref_regs[2] = 8'h56;
    ref_regs[3] = 8'h10;
    flash_mem = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};

    // Reset state, flash pads follow the SoC side
    soc_flash_csb = 1'b1; soc_flash_clk = 1'b1; soc_flash_io0 = 1'b1;
    tick(3);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_sdo_enb", 32'(sdo_enb), 32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd0);
    check("rst_pads_111", 32'({flash_csb, flash_clk, flash_io0}), 32'b111);
    soc_flash_clk = 1'b0; soc_flash_io0 = 1'b0;
    #1 check("rst_pads_100", 32'({flash_csb, flash_clk, flash_io0}), 32'b100);
    resetb = 1'b1;
    tick(3);

    // Product ID read with sdo_enb behaviour
    cs_low();
    check("enb_in_frame", 32'(sdo_enb), 32'd0);
    xfer(8'h40, rx);
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    check("prod_id", 32'(rx), 32'h10);
    cs_high();
    check("enb_after_frame", 32'(sdo_enb), 32'd1);

    // Stream read with auto-increment
    frame_read(8'h40, 8'h01, 3);
    check("stream_b0", 32'(rbuf[0]), 32'h04);
    check("stream_b1", 32'(rbuf[1]), 32'h56);
    check("stream_b2", 32'(rbuf[2]), 32'h10);

    // Counted read of 2 stops; third byte reads 0
    frame_read(8'h50, 8'h01, 3);
    check("cnt_b0", 32'(rbuf[0]), 32'h04);
    check("cnt_b1", 32'(rbuf[1]), 32'h56);
    check("cnt_b2_stopped", 32'(rbuf[2]), 32'h00);

    // Address wrap 0xFF -> 0x00
    frame_read(8'h40, 8'hFF, 3);
    check("wrap_ff", 32'(rbuf[0]), 32'h00);
    check("wrap_00", 32'(rbuf[1]), 32'h00);
    check("wrap_01", 32'(rbuf[2]), 32'h04);

    // CPU reset register
    wbuf[0] = 8'h01;
    frame_write(8'h80, 8'h08, 1);
    check("wr_cpu_reset_1", 32'(cpu_reset), 32'd1);
    wbuf[0] = 8'h00;
    frame_write(8'h80, 8'h08, 1);
    check("wr_cpu_reset_0", 32'(cpu_reset), 32'd0);
    frame_read(8'h40, 8'h08, 1);
    check("rd_reg08", 32'(rbuf[0]), 32'h00);

    // Counted write of 1 byte: the extra byte must not reach 0x09 or 0x08
    wbuf[0] = 8'h01; wbuf[1] = 8'h00;
    frame_write(8'h88, 8'h08, 2);
    check("cnt_wr_cpu_reset", 32'(cpu_reset), 32'd1);
    wbuf[0] = 8'h00;
    frame_write(8'h80, 8'h08, 1);
    check("cpu_reset_clear", 32'(cpu_reset), 32'd0);

    // Read-only register ignores writes
    wbuf[0] = 8'hAA;
    frame_write(8'h80, 8'h03, 1);
    frame_read(8'h40, 8'h03, 1);
    check("ro_prod_id", 32'(rbuf[0]), 32'h10);

    // Pass-thru read of the flash model
    cs_low();
    check("pt_flash_csb_pre", 32'(flash_csb), 32'd1);
    check("pt_cpu_reset_pre", 32'(cpu_reset), 32'd0);
    xfer(8'hC4, rx);
    tick(2);
    check("pt_flash_csb_on", 32'(flash_csb), 32'd0);
    check("pt_cpu_reset_on", 32'(cpu_reset), 32'd1);
    fl_base = fl_cnt;
    xfer(8'h03, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    xfer(8'h00, rx);
    check("pt_cpu_reset_mid", 32'(cpu_reset), 32'd1);
    for (int i = 0; i < 8; i++) begin
      xfer(8'h00, rx);
      check($sformatf("pt_data%0d", i), 32'(rx), 32'(flash_mem[i]));
    end
    check("pt_cpu_reset_end", 32'(cpu_reset), 32'd1);
    tick(2);
    csb = 1'b1;
    #1 check("pt_exit_flash_csb", 32'(flash_csb), 32'd1);
    tick(3);
    check("pt_exit_cpu_reset", 32'(cpu_reset), 32'd0);
    soc_flash_csb = 1'b0; soc_flash_clk = 1'b1; soc_flash_io0 = 1'b1;
    #1 check("pt_exit_pads", 32'({flash_csb, flash_clk, flash_io0}), 32'b011);
    soc_flash_csb = 1'b1; soc_flash_clk = 1'b0; soc_flash_io0 = 1'b0;
    tick(6);
    frame_read(8'h40, 8'h03, 1);
    check("pt_after_prod_id", 32'(rbuf[0]), 32'h10);

    // resetb pulse during pass-thru aborts immediately
    cs_low();
    xfer(8'hC4, rx);
    tick(2);
    check("abort_pt_active", 32'(cpu_reset), 32'd1);
    resetb = 1'b0;
    #1 check("abort_flash_csb", 32'(flash_csb), 32'd1);
    check("abort_cpu_reset", 32'(cpu_reset), 32'd0);
    tick(2);
    csb = 1'b1;
    tick(2);
    resetb = 1'b1;
    tick(6);

    // csb raised after 5 command bits; the next frame decodes normally
    cs_low();
    for (int i = 7; i >= 3; i--) begin
      sdi = 1'b1;
      tick(HALF);
      sck = 1'b1;
      tick(HALF);
      sck = 1'b0;
    end
    cs_high();
    frame_read(8'h40, 8'h03, 1);
    check("partial_then_read", 32'(rbuf[0]), 32'h10);

`ifndef USER_PASSTHRU_EN
    // 0xC6 is unknown in this build
    cs_low();
    xfer(8'hC6, rx);
    tick(2);
    check("c6_cpu_reset", 32'(cpu_reset), 32'd0);
    check("c6_flash_csb", 32'(flash_csb), 32'd1);
    xfer(8'hFF, rx);
    check("c6_sdo_b0", 32'(rx), 32'h00);
    xfer(8'h00, rx);
    check("c6_sdo_b1", 32'(rx), 32'h00);
    cs_high();
`endif

    // Randomized transactions against the register-map model
    for (int t = 0; t < 24; t++) begin
      op = int'($urandom_range(0, 3));
      n  = int'($urandom_range(1, 4));
      case ($urandom_range(0, 2))
        0:       a = 8'($urandom_range(0, 15));
        1:       a = 8'(8'hF8 + $urandom_range(0, 7));
        default: a = 8'h08 - 8'($urandom_range(0, 1));
      endcase
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      case (op)
        0: begin
          frame_read(8'h40, a, n);
          for (int i = 0; i < n; i++) begin
            idx = a + 8'(i);
            check($sformatf("rnd%0d_srd@%0h", t, idx), 32'(rbuf[i]), 32'(ref_regs[idx]));
          end
        end
        1: begin
          frame_read(8'h40 | 8'(n << 3), a, n + 1);
          for (int i = 0; i < n; i++) begin
            idx = a + 8'(i);
            check($sformatf("rnd%0d_crd@%0h", t, idx), 32'(rbuf[i]), 32'(ref_regs[idx]));
          end
          check($sformatf("rnd%0d_crd_end", t), 32'(rbuf[n]), 32'd0);
        end
        2: begin
          frame_write(8'h80, a, n);
          for (int i = 0; i < n; i++) ref_write(a + 8'(i), wbuf[i]);
        end
        default: begin
          frame_write(8'hC0, a, n);
          for (int i = 0; i < n; i++) begin
            idx = a + 8'(i);
            check($sformatf("rnd%0d_rw@%0h", t, idx), 32'(rbuf[i]), 32'(ref_regs[idx]));
            ref_write(idx, wbuf[i]);
          end
        end
      endcase
      check($sformatf("rnd%0d_cpu_reset", t), 32'(cpu_reset), 32'(ref_regs[8][0]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
